// File: rtl/digit_serial_adder_if.sv
// rtl/digit_serial_adder_if.sv - operand/result handshake bundle for digit_serial_adder (sub/overflow under SUB_MODE_EN)
interface digit_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] augend;
  logic [WIDTH-1:0] addend;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;
`ifdef SUB_MODE_EN
  logic             sub;
  logic             overflow;

  modport master (
    output in_valid, augend, addend, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, busy
  );
  modport slave (
    input  in_valid, augend, addend, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, busy
  );
`else
  modport master (
    output in_valid, augend, addend, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );
  modport slave (
    input  in_valid, augend, addend, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );
`endif
endinterface

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle adder, DIGIT bits per clock, LSB digit first
// Define SUB_MODE_EN to add the sub input (inverted addend) and signed overflow output.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  digit_serial_adder_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, b_in, sum_q, dmask;
  logic [NDIG-1:0]  dsel;
  logic             carry_q, cout_q;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic             last;

  // One ripple slice reused every cycle; operands shift down so digit k sits at bit 0.
  assign c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    full_adder u_fa (
      .a  (a_sh[i]),
      .b  (b_sh[i]),
      .ci (c[i]),
      .s  (dsum[i]),
      .co (c[i+1])
    );
  end

  // dsel is a one-hot digit pointer; dmask expands it to the sum bits of that digit.
  for (genvar j = 0; j < NDIG; j++) begin : g_mask
    assign dmask[j*DIGIT +: DIGIT] = {DIGIT{dsel[j]}};
  end
  assign last = dsel[NDIG-1];

`ifdef SUB_MODE_EN
  logic ovf_q;
  assign b_in         = bus.sub ? ~bus.addend : bus.addend;
  assign bus.overflow = ovf_q;
`else
  assign b_in = bus.addend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      dsel    <= NDIG'(1);
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SUB_MODE_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh    <= bus.augend;
            b_sh    <= b_in;
            carry_q <= bus.carry_in;
            dsel    <= NDIG'(1);
            sum_q   <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          carry_q <= c[DIGIT];
          sum_q   <= (sum_q & ~dmask) | ({NDIG{dsum}} & dmask);
          dsel    <= dsel << 1;
          if (last) begin
            cout_q <= c[DIGIT];
`ifdef SUB_MODE_EN
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf_q  <= c[DIGIT] ^ c[DIGIT-1];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
endmodule
